wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back stage and register file of the five-stage pipeline. Consumes the MEM/WB latch outputs: write-back control, memory read data, ALU result and destination register. Selects the write-back value, commits it to a 32-entry register file on the clock edge and serves the two ID-stage read ports. Also keeps a committed-write counter for debug and performance checks.

## Interface
- DATA_W, 32, register and data width
- ADDR_W, 5, register address width; entry count is 2**ADDR_W
- CNT_W, 32, committed-write counter width

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- mem_control_wb  input  2  bit[1] = RegWrite, bit[0] = MemtoReg
- Read_data  input  DATA_W  load data from the MEM/WB latch
- mem_ALU_result  input  DATA_W  ALU result from the MEM/WB latch
- mem_Write_reg  input  ADDR_W  destination register
- rs_addr  input  ADDR_W  read port A address (ID stage)
- rt_addr  input  ADDR_W  read port B address (ID stage)
- rs_data  output  DATA_W  read port A data
- rt_data  output  DATA_W  read port B data
- wb_data  output  DATA_W  selected write-back value, for EX forwarding
- wb_we  output  1  effective write enable, for the forwarding unit
- wb_reg  output  ADDR_W  mirrors mem_Write_reg
- wr_count  output  CNT_W  number of committed register writes

## Operation
- wb_data = MemtoReg ? Read_data : mem_ALU_result. This is combinational.
- wb_we = RegWrite && (mem_Write_reg != 0). Writes to $0 are dropped.
- On a rising clk edge with wb_we = 1: regs[mem_Write_reg] <= wb_data, and wr_count increments by 1.
- wr_count wraps modulo 2**CNT_W. It does not saturate.
- Reads are combinational: rs_data = regs[rs_addr] and rt_data = regs[rt_addr].
- Address 0 always reads 0, independent of storage contents or bypass.
- Both read ports may address the same register. Each returns the identical value.
- RegWrite = 0 with MemtoReg = 1 is legal. wb_data is still driven, but nothing is written.
- An X or Z value on mem_control_wb is a bench error. No recovery is defined.

## Timing
- Reset, asynchronous: all registers clear to 0 and wr_count clears to 0. rs_data and rt_data read 0 while rst = 1. wb_data, wb_we and wb_reg follow their inputs even during reset.
- A reset asserted mid-cycle aborts any pending write. The first write can commit on the first rising edge after rst deasserts.
- Write latency:
  - The value is stored at the edge ending the WB cycle.
  - Without bypass, a read of the same register returns the new value from the next cycle.
  - With bypass, see Configuration.
- There is no stall or handshake. Every cycle with wb_we = 1 commits exactly one write.
- The MEM/WB latch upstream owns pipeline timing. This block adds no cycles.

## Configuration
- WB_BYPASS_EN defined: a read port returns wb_data in the same cycle when wb_we = 1, the read address equals mem_Write_reg, and the address is non-zero. This gives write-before-read semantics in the same cycle, so ID sees the WB value without a forwarding path.
- WB_BYPASS_EN undefined: read ports return stored contents only. Same-cycle read-after-write returns the old value, and the hazard unit must stall or forward.

## Structure
- The shared pipeline package holds:
  - WB_REGWRITE_BIT = 1 and WB_MEMTOREG_BIT = 0
  - ZERO_REG = 0
  - DATA_W and ADDR_W defaults
- Sub-module regfile_2r1w: the storage array with async reset, one write port, two combinational read ports, the $0 forcing and the optional bypass.
- The top level holds the write-back mux, the wb_we qualification and wr_count.

## Test plan
- Reset: preload r5 = 0x1234, assert rst mid-cycle -> rs_data(r5) = 0 and wr_count = 0 immediately, before any clock edge.
- ALU write-back: control = 2'b10, ALU = 0xDEADBEEF, reg = 8, one edge -> rs_addr = 8 reads 0xDEADBEEF and wr_count = 1.
- Load write-back: control = 2'b11, Read_data = 0x0000_00FF, ALU = 0x5555_5555, reg = 3 -> wb_data = 0xFF and r3 = 0xFF after the edge.
- Zero register and no write:
  - control = 2'b10, reg = 0, data 0xFFFF_FFFF -> r0 reads 0, wb_we = 0, wr_count unchanged.
  - control = 2'b01 -> no register changes.
- Same-cycle RAW: write r9 = 0xA5A5_A5A5 while rs_addr = rt_addr = 9 -> with WB_BYPASS_EN both ports read 0xA5A5_A5A5 before the edge. Without it, both read the prior value until after the edge.
- Counter wrap: with CNT_W = 4, perform 17 writes -> wr_count = 1.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared pipeline constants for the write-back stage and register file.
// Build option: WB_BYPASS_EN enables same-cycle write-to-read bypass.
package wb_regfile_pkg;
  localparam int DATA_W_DEF      = 32;
  localparam int ADDR_W_DEF      = 5;
  localparam int WB_REGWRITE_BIT = 1;
  localparam int WB_MEMTOREG_BIT = 0;
  localparam int ZERO_REG        = 0;
endpackage

// File: rtl/regfile_2r1w.sv
// Register storage: one write port, two combinational read ports.
// Build option: WB_BYPASS_EN returns wdata on a same-cycle address hit.
module regfile_2r1w
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int N = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs_q [N];
  logic [DATA_W-1:0] regs_d [N];

  always_comb begin
    regs_d = regs_q;
    if (we && waddr != ZA) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  function automatic logic [DATA_W-1:0] rd(
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W-1:0] v;
    v = regs_q[a];
`ifdef WB_BYPASS_EN
    // Write-before-read; reset forces reads to zero.
    if (we && !rst && a == waddr) begin
      v = wdata;
    end
`endif
    if (a == ZA) begin
      v = '0;
    end
    return v;
  endfunction

  always_comb begin
    rdata_a = rd(raddr_a);
    rdata_b = rd(raddr_b);
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: result mux, write qualification, commit counter.
// Build option: WB_BYPASS_EN (see regfile_2r1w).
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mem_control_wb,
  input  logic [DATA_W-1:0] Read_data,
  input  logic [DATA_W-1:0] mem_ALU_result,
  input  logic [ADDR_W-1:0] mem_Write_reg,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_reg,
  output logic [CNT_W-1:0]  wr_count
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    wb_data = mem_control_wb[WB_MEMTOREG_BIT]
            ? Read_data : mem_ALU_result;
    wb_we   = mem_control_wb[WB_REGWRITE_BIT]
           && (mem_Write_reg != ADDR_W'(ZERO_REG));
    wb_reg  = mem_Write_reg;
    cnt_d   = cnt_q + CNT_W'(wb_we);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign wr_count = cnt_q;

  regfile_2r1w #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_we),
    .waddr  (mem_Write_reg),
    .wdata  (wb_data),
    .raddr_a(rs_addr),
    .raddr_b(rt_addr),
    .rdata_a(rs_data),
    .rdata_b(rt_data)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile against a behavioural model.
// Build option: WB_BYPASS_EN selects bypass expectations.
module tb_wb_regfile;
  localparam int CW = 4;

  logic        clk = 0;
  logic        rst = 1;
  logic [1:0]  ctrl = 0;
  logic [31:0] rdat = 0, alu = 0;
  logic [4:0]  wreg = 0, rs = 0, rt = 0;
  logic [31:0] rs_data, rt_data, wb_data;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [CW-1:0] wr_count;

  wb_regfile #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .mem_control_wb(ctrl),
    .Read_data(rdat),
    .mem_ALU_result(alu),
    .mem_Write_reg(wreg),
    .rs_addr(rs), .rt_addr(rt),
    .rs_data(rs_data), .rt_data(rt_data),
    .wb_data(wb_data), .wb_we(wb_we),
    .wb_reg(wb_reg), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  logic [31:0] m_regs [32];
  int unsigned m_cnt;
  int checks = 0;
  int passes = 0;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  function automatic logic [31:0] m_wbd();
    return ctrl[0] ? rdat : alu;
  endfunction

  function automatic logic m_we();
    return ctrl[1] && (wreg != 0);
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    if (a == 0 || rst) return 32'h0;
    if (BYP && m_we() && a == wreg) return m_wbd();
    return m_regs[a];
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_cnt = 0;
  endtask

  task automatic check_comb(input string tag);
    chk({tag, ".wb_data"}, wb_data, m_wbd());
    chk({tag, ".wb_we"}, {31'h0, wb_we}, {31'h0, m_we()});
    chk({tag, ".wb_reg"}, {27'h0, wb_reg}, {27'h0, wreg});
    chk({tag, ".rs"}, rs_data, m_rd(rs));
    chk({tag, ".rt"}, rt_data, m_rd(rt));
  endtask

  // Drive one WB cycle from a negedge, check, then commit.
  task automatic step(input string tag,
                      input logic [1:0] c,
                      input logic [31:0] rd_v,
                      input logic [31:0] alu_v,
                      input logic [4:0] w,
                      input logic [4:0] a,
                      input logic [4:0] b);
    @(negedge clk);
    ctrl = c; rdat = rd_v; alu = alu_v;
    wreg = w; rs = a; rt = b;
    #1 check_comb(tag);
    @(posedge clk);
    if (m_we()) begin
      m_regs[wreg] = m_wbd();
      m_cnt = (m_cnt + 1) % (1 << CW);
    end
    #1;
    ctrl = 2'b00;
    chk({tag, ".cnt"}, {28'h0, wr_count}, m_cnt);
  endtask

  task automatic peek(input string tag, input logic [4:0] a);
    @(negedge clk);
    ctrl = 2'b00; rs = a; rt = a;
    #1;
    chk({tag, ".rs"}, rs_data, m_rd(a));
    chk({tag, ".rt"}, rt_data, m_rd(a));
  endtask

  initial begin
    m_clear();
    #2;
    chk("rst0.rs", rs_data, 32'h0);
    chk("rst0.cnt", {28'h0, wr_count}, 32'h0);
    @(negedge clk);
    rst = 0;

    step("pre5", 2'b10, 32'h0, 32'h1234, 5'd5, 5'd5, 5'd0);
    peek("pre5r", 5'd5);
    chk("pre5.val", rs_data, 32'h1234);

    // Mid-cycle reset with a write pending.
    @(negedge clk);
    ctrl = 2'b10; alu = 32'hCAFE_0001; wreg = 5'd5;
    rs = 5'd5; rt = 5'd5;
    #2 rst = 1;
    #1;
    m_clear();
    chk("rst1.rs", rs_data, 32'h0);
    chk("rst1.rt", rt_data, 32'h0);
    chk("rst1.cnt", {28'h0, wr_count}, 32'h0);
    chk("rst1.wbd", wb_data, 32'hCAFE_0001);
    chk("rst1.we", {31'h0, wb_we}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    rst = 0; ctrl = 2'b00;
    peek("rst1.after", 5'd5);
    chk("rst1.cnt2", {28'h0, wr_count}, 32'h0);

    step("alu", 2'b10, 32'h0, 32'hDEAD_BEEF, 5'd8, 5'd0, 5'd0);
    peek("alu.r8", 5'd8);
    chk("alu.val", rs_data, 32'hDEAD_BEEF);
    chk("alu.cnt", {28'h0, wr_count}, 32'h1);

    step("ld", 2'b11, 32'hFF, 32'h5555_5555, 5'd3, 5'd3, 5'd8);
    chk("ld.wbd", wb_data, 32'hFF);
    peek("ld.r3", 5'd3);
    chk("ld.val", rs_data, 32'hFF);

    step("z0", 2'b10, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    chk("z0.cnt", {28'h0, wr_count}, 32'h2);
    step("nowr", 2'b01, 32'h7777, 32'h0, 5'd3, 5'd3, 5'd8);
    peek("nowr.r3", 5'd3);
    chk("nowr.val", rs_data, 32'hFF);

    step("raw0", 2'b10, 32'h0, 32'h11, 5'd9, 5'd0, 5'd0);
    step("raw", 2'b10, 32'h0, 32'hA5A5_A5A5, 5'd9, 5'd9, 5'd9);
    peek("raw.after", 5'd9);
    chk("raw.val", rs_data, 32'hA5A5_A5A5);

    for (int i = 0; i < 200; i++) begin
      step("rnd", 2'($urandom_range(0, 3)), $urandom,
           $urandom, 5'($urandom), 5'($urandom),
           5'($urandom));
    end

    // Counter wrap: 17 commits from reset.
    @(negedge clk);
    rst = 1;
    #1 m_clear();
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 17; i++) begin
      step("wrap", 2'b10, 32'h0, i, 5'(i % 31 + 1),
           5'd1, 5'd2);
    end
    chk("wrap.cnt", {28'h0, wr_count}, 32'h1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=done");
    $fatal(1, "timeout");
  end
endmodule
